// File: rtl/present_ctr_uut_wrapper.sv
// present_ctr_uut_wrapper
// Drives one PRESENT block-cipher core in CTR mode on behalf of the autotest FSM.
// Each request forms the counter block (IV + index), launches the core, waits for
// the keystream, XORs it with the latched data and reports completion.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   rq_uut             request level; a rising edge starts one block
//   end_stage_1_uut    keystream captured (core finished)
//   end_uut            block complete, output_from_UUT_1 valid
//   input_to_UUT_1..4  data, IV, key, block index
//   output_from_UUT_1  data XOR keystream (0 after a timeout)
//   timeout_err        core did not answer within TIMEOUT_CYCLES
//   core_start/key/din one-cycle start pulse, key and counter block to the core
//   core_done/dout     completion pulse and keystream from the core
//
// Optional feature: define CTR_AUTO_INC_EN to use IV + index only for the first
// request after reset; later requests use the last successful counter + 1.
module present_ctr_uut_wrapper #(
    parameter int unsigned BLOCK_SIZE     = 64,
    parameter int unsigned KEY_SIZE       = 80,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rq_uut,
    output logic                  end_stage_1_uut,
    output logic                  end_uut,
    input  logic [BLOCK_SIZE-1:0] input_to_UUT_1,
    input  logic [BLOCK_SIZE-1:0] input_to_UUT_2,
    input  logic [KEY_SIZE-1:0]   input_to_UUT_3,
    input  logic [31:0]           input_to_UUT_4,
    output logic [BLOCK_SIZE-1:0] output_from_UUT_1,
    output logic                  timeout_err,
    output logic                  core_start,
    output logic [KEY_SIZE-1:0]   core_key,
    output logic [BLOCK_SIZE-1:0] core_din,
    input  logic                  core_done,
    input  logic [BLOCK_SIZE-1:0] core_dout
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitCore,
        StXor,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic                  rq_d;
    logic                  start_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [BLOCK_SIZE-1:0] ctr_reg;
    logic [BLOCK_SIZE-1:0] data_reg;
    logic [BLOCK_SIZE-1:0] ks_reg;
    logic [BLOCK_SIZE-1:0] ctr_base;
    logic [BLOCK_SIZE-1:0] ctr_next;

    // Addition wraps naturally at BLOCK_SIZE bits.
    assign ctr_base = input_to_UUT_2 + BLOCK_SIZE'(input_to_UUT_4);

`ifdef CTR_AUTO_INC_EN
    // ctr_reg holds the last successfully used counter; din_q the one in flight,
    // so a timed-out block does not advance the sequence.
    logic                  ctr_init_q;
    logic [BLOCK_SIZE-1:0] din_q;
    assign ctr_next = ctr_init_q ? ctr_reg + BLOCK_SIZE'(1) : ctr_base;
    assign core_din = din_q;
`else
    assign ctr_next = ctr_base;
    assign core_din = ctr_reg;
`endif

    assign core_start = (state_q == StStart);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (start_q) state_d = StLoad;
            StLoad:     state_d = StStart;
            StStart:    state_d = StWaitCore;
            StWaitCore: begin
                // core_done takes priority over the final timeout count.
                if (core_done) begin
                    state_d = StXor;
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StXor:      state_d = StDone;
            StDone:     if (!rq_uut) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rq_d              <= 1'b0;
            start_q           <= 1'b0;
            cnt_q             <= '0;
            ctr_reg           <= '0;
            data_reg          <= '0;
            ks_reg            <= '0;
            core_key          <= '0;
            output_from_UUT_1 <= '0;
            end_stage_1_uut   <= 1'b0;
            end_uut           <= 1'b0;
            timeout_err       <= 1'b0;
`ifdef CTR_AUTO_INC_EN
            ctr_init_q        <= 1'b0;
            din_q             <= '0;
`endif
        end else begin
            rq_d    <= rq_uut;
            // Registered edge detect; only consumed in IDLE, so edges are never queued.
            start_q <= rq_uut & ~rq_d;
            case (state_q)
                StIdle: begin
                    if (start_q) begin
                        data_reg <= input_to_UUT_1;
                        core_key <= input_to_UUT_3;
                    end
                end
                StLoad: begin
`ifdef CTR_AUTO_INC_EN
                    din_q   <= ctr_next;
`else
                    ctr_reg <= ctr_next;
`endif
                end
                StStart: cnt_q <= '0;
                StWaitCore: begin
                    if (core_done) begin
                        ks_reg          <= core_dout;
                        end_stage_1_uut <= 1'b1;
                    end else if (cnt_q == CntLast) begin
                        timeout_err       <= 1'b1;
                        end_uut           <= 1'b1;
                        output_from_UUT_1 <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                StXor: begin
                    output_from_UUT_1 <= data_reg ^ ks_reg;
                    end_uut           <= 1'b1;
`ifdef CTR_AUTO_INC_EN
                    ctr_reg           <= din_q;
                    ctr_init_q        <= 1'b1;
`endif
                end
                StDone: begin
                    if (!rq_uut) begin
                        end_uut         <= 1'b0;
                        end_stage_1_uut <= 1'b0;
                        timeout_err     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_present_ctr_uut_wrapper.sv
// Self-checking bench for present_ctr_uut_wrapper: a behavioural core model answers
// core_start after a programmable latency, and a reference model predicts counter
// block, result, latency and handshake behaviour for directed and random blocks.
module tb_present_ctr_uut_wrapper;

    localparam int unsigned TO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        rq_uut;
    logic        end_stage_1_uut;
    logic        end_uut;
    logic [63:0] in_data;
    logic [63:0] in_iv;
    logic [79:0] in_key;
    logic [31:0] in_idx;
    logic [63:0] out_data;
    logic        timeout_err;
    logic        core_start;
    logic [79:0] core_key;
    logic [63:0] core_din;
    logic        core_done = 1'b0;
    logic [63:0] core_dout = 64'd0;

    present_ctr_uut_wrapper #(
        .BLOCK_SIZE    (64),
        .KEY_SIZE      (80),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rq_uut           (rq_uut),
        .end_stage_1_uut  (end_stage_1_uut),
        .end_uut          (end_uut),
        .input_to_UUT_1   (in_data),
        .input_to_UUT_2   (in_iv),
        .input_to_UUT_3   (in_key),
        .input_to_UUT_4   (in_idx),
        .output_from_UUT_1(out_data),
        .timeout_err      (timeout_err),
        .core_start       (core_start),
        .core_key         (core_key),
        .core_din         (core_din),
        .core_done        (core_done),
        .core_dout        (core_dout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core model: sees core_start on a falling edge and answers with a one-cycle
    // core_done that the DUT samples lat_cfg rising edges after it sampled core_start.
    int          lat_cfg = 0;
    logic [63:0] ks_cfg = 64'd0;
    int          cd = 0;
    int          start_cnt = 0;
    int          done_cnt = 0;
    logic [63:0] seen_din = 64'd0;
    logic [79:0] seen_key = 80'd0;

    always @(negedge clk) begin
        core_done = 1'b0;
        if (core_start) begin
            start_cnt++;
            seen_din = core_din;
            seen_key = core_key;
            cd = lat_cfg;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                core_done = 1'b1;
                core_dout = ks_cfg;
                done_cnt++;
            end
        end
    end

    // Reference counter state for the auto-increment build.
    bit          ctr_valid = 1'b0;
    logic [63:0] last_ctr = 64'd0;

    function automatic logic [63:0] ref_ctr(input logic [63:0] iv, input logic [31:0] idx);
`ifdef CTR_AUTO_INC_EN
        if (ctr_valid) return last_ctr + 64'd1;
`endif
        return iv + {32'd0, idx};
    endfunction

    task automatic run_block(input logic [63:0] data, input logic [63:0] iv,
                             input logic [79:0] key, input logic [31:0] idx,
                             input logic [63:0] ks, input int lat,
                             input bit toggle, input int hold);
        logic [63:0] exp_din;
        logic [63:0] exp_out;
        bit          tmo;
        bit          got;
        int          n;
        int          es1_n;
        int          s0;
        exp_din = ref_ctr(iv, idx);
        tmo     = (lat == 0) || (lat > int'(TO));
        exp_out = tmo ? 64'd0 : (data ^ ks);
        s0      = start_cnt;
        @(posedge clk); #1;
        lat_cfg = lat;
        ks_cfg  = ks;
        in_data = data;
        in_iv   = iv;
        in_key  = key;
        in_idx  = idx;
        rq_uut  = 1'b1;
        n = 0; got = 0; es1_n = -1;
        while (!got && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (end_stage_1_uut && es1_n < 0) es1_n = n;
            if (end_uut) got = 1;
            if (n == 4) begin
                in_data = {$urandom, $urandom};
                in_iv   = {$urandom, $urandom};
                in_key  = {$urandom, $urandom, $urandom};
                in_idx  = $urandom;
            end
            if (toggle && n == 6) rq_uut = 1'b0;
            if (toggle && n == 7) rq_uut = 1'b1;
        end
        if (!got) begin
            check_eq("end_uut_seen", 0, 1);
        end else begin
            check_eq("core_din", seen_din, exp_din);
            check_eq("core_key", seen_key, key);
            check_eq("start_pulses", start_cnt - s0, 1);
            check_eq("result", out_data, exp_out);
            check_eq("timeout_err", timeout_err, tmo);
            check_eq("latency", n, tmo ? int'(TO) + 4 : lat + 5);
            check_eq("stage1_cycle", es1_n, tmo ? -1 : lat + 4);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_eq("hold_end_uut", end_uut, 1);
            check_eq("hold_result", out_data, exp_out);
        end
        rq_uut = 1'b0;
        @(posedge clk); #1;
        check_eq("rel_end_uut", end_uut, 0);
        check_eq("rel_stage1", end_stage_1_uut, 0);
        check_eq("rel_timeout", timeout_err, 0);
        check_eq("rel_result", out_data, exp_out);
        check_eq("extra_starts", start_cnt - s0, 1);
        if (!tmo) begin
            ctr_valid = 1'b1;
            last_ctr  = exp_din;
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_end"}, {end_uut, end_stage_1_uut, timeout_err, core_start}, 4'd0);
        check_eq({tag, "_out"}, out_data, 64'd0);
        check_eq({tag, "_key"}, core_key, 80'd0);
        check_eq({tag, "_din"}, core_din, 64'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b0;
        rq_uut = 1'b0;
        in_data = '0; in_iv = '0; in_key = '0; in_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Basic block with the known PRESENT keystream for an all-zero key/counter.
        run_block(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 80'd0, 32'd0,
                  64'h5579C1387B228445, 32, 1'b1, 3);

        // Reset while waiting on the core; its late core_done lands in IDLE.
        d0 = done_cnt;
        @(posedge clk); #1;
        lat_cfg = 20;
        in_data = 64'h1234; in_iv = 64'h55; in_key = 80'h77; in_idx = 32'd3;
        rq_uut = 1'b1;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b0;
        rq_uut = 1'b0;
        #1;
        check_zero("abort");
        ctr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check_eq("stray_done_sent", done_cnt - d0, 1);
        check_zero("stray");

        // Counter wrap, then a second request (auto-increment gives 1).
        run_block(64'hA5A5, 64'hFFFF_FFFF_FFFF_FFFF, 80'h1, 32'd1, 64'h0F0F, 5, 1'b0, 0);
        run_block(64'h3C3C, 64'hFFFF_FFFF_FFFF_FFFF, 80'h2, 32'd1, 64'hF00D, 3, 1'b0, 1);

        // Timeout, then done on the final count, then minimum latency.
        run_block(64'hDEAD, 64'h100, 80'h3, 32'd7, 64'hBEEF, 0, 1'b0, 2);
        run_block(64'h1111, 64'h200, 80'h4, 32'd9, 64'h2222, int'(TO), 1'b1, 0);
        run_block(64'h3333, 64'h300, 80'h5, 32'hFFFF_FFFF, 64'h4444, 1, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            int lat;
            lat = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TO));
            run_block({$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom, $urandom}, $urandom, {$urandom, $urandom},
                      lat, (lat >= 8) && $urandom_range(0, 1) == 1, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
